apb_uart_ctrl: RTL and testbench
================================

Name: apb_uart_ctrl

Overview:
- APB3 master that sequences the 16550-style APB UART slave. It runs the register init sequence, then polls LSR to move bytes between valid/ready byte streams and the THR/RBR registers.
- Sits between a core-side byte producer/consumer and the UART APB slave port. It is the only master on that UART's APB segment.

Parameters:
- ADDR_WIDTH, 12, APB address width
- DATA_WIDTH, 32, APB data width
- BASE_ADDR, 12'h000, UART base address; register n sits at BASE_ADDR + (n<<2)
- DIVISOR, 16'd27, baud divisor written to DLM:DLL
- LCR_VAL, 8'h03, final LCR value (8N1, DLAB=0)
- FCR_VAL, 8'h07, FIFO enable + clear RX/TX FIFOs
- IER_VAL, 8'h00, interrupt enable value

Ports:
- pclk  in  1  clock
- preset  in  1  asynchronous active-high reset
- cfg_start  in  1  pulse: (re)run init sequence; ignored while busy
- init_done  out  1  high once init has completed without error
- err  out  1  sticky; set on pslverr; cleared by cfg_start
- tx_valid  in  1  byte available to send
- tx_data  in  8  byte to send
- tx_ready  out  1  byte accepted this cycle
- rx_valid  out  1  received byte held
- rx_data  out  8  received byte
- rx_ready  in  1  consumer takes rx_data
- paddr  out  ADDR_WIDTH  APB address
- pselx  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_WIDTH  write data; byte in [7:0], upper bits zero
- prdata  in  DATA_WIDTH  read data; only [7:0] used
- pready  in  1  slave ready
- pslverr  in  1  slave error, sampled with pready

Behaviour:
- Reset (preset=1, async): all outputs 0; FSM to IDLE; rx holding register empty; err=0; init_done=0.
- APB sub-FSM is the only driver of the bus:
  - SETUP: pselx=1, penable=0, for exactly 1 cycle.
  - ACCESS: pselx=1, penable=1, held until pready=1.
  - Then return to IDLE with pselx=0 for at least 1 cycle between transfers.
  - paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS.
  - Minimum 2 cycles per transfer.
- Main FSM states: IDLE, INIT (6-step sequence), POLL_LSR, RD_RBR, WR_THR, HALT.
- IDLE: on cfg_start, clear err and init_done, then go to INIT.
- INIT writes, in order:
  1. LCR = LCR_VAL | 8'h80 (DLAB=1)
  2. DLL = DIVISOR[7:0]
  3. DLM = DIVISOR[15:8]
  4. LCR = LCR_VAL & 8'h7F
  5. FCR = FCR_VAL
  6. IER = IER_VAL
- After the last write completes: init_done=1, go to POLL_LSR.
- POLL_LSR: read LSR. On completion, decide from the captured LSR value:
  - LSR[0]=1 and rx holding register empty: go to RD_RBR (RX has priority over TX).
  - Otherwise, if tx_valid=1 and LSR[5]=1: tx_ready=1 for exactly that cycle, capture tx_data, go to WR_THR.
  - Otherwise: poll LSR again.
- RD_RBR: read RBR; on completion load prdata[7:0] into the holding register and set rx_valid=1. Return to POLL_LSR.
- WR_THR: write the captured byte to THR; return to POLL_LSR.
- rx_valid stays high until rx_ready=1. The register clears the cycle after rx_valid&&rx_ready, and can reload no earlier than the following RBR completion.
- tx_ready is never asserted outside the POLL_LSR decision cycle. tx_data must not be sampled at any other time.
- pslverr=1 on any completing transfer:
  - err=1 and init_done=0; go to HALT after the transfer closes.
  - HALT issues no bus traffic and leaves only via cfg_start, which re-enters INIT.
- cfg_start while not in IDLE/HALT is ignored.
- Async reset mid-transfer drops pselx/penable immediately. Any captured TX byte and the rx holding register are discarded.
- Bus wait states are unbounded; there is no timeout.

Decomposition:
- Package apb_uart_pkg holds:
  - the register offset constants RBR/THR/DLL = 0, IER/DLM = 1, IIR/FCR = 2, LCR = 3, MCR = 4, LSR = 5, MSR = 6, SCR = 7
  - LSR bit indices LSR_DR = 0, LSR_THRE = 5
  - enum typedefs for main and APB states
- One sub-module, apb_uart_master_if: the APB SETUP/ACCESS engine.
  - Inputs: req, we, addr, wdata.
  - Outputs: done, rdata, slverr.
  - The main FSM in apb_uart_ctrl drives it.

Test Plan:
- Init, pready tied high: cfg_start pulse -> writes in order:
  - addr 0x00C=0x83, 0x000=0x1B, 0x004=0x00, 0x00C=0x03, 0x008=0x07, 0x004=0x00
  - each write takes 2 cycles with 1 idle cycle between writes; init_done=1 after the 6th.
- TX: LSR returns 0x60, tx_valid with tx_data=0xA5 -> one tx_ready pulse, then write paddr 0x000 pwdata 0x000000A5. With LSR=0x00, tx_ready stays 0 over 20 polls.
- RX with backpressure:
  - LSR=0x61, RBR=0x3C, rx_ready=0 -> rx_valid=1, rx_data=0x3C.
  - No further RBR read while held, even with LSR[0]=1; TX still serviced.
  - rx_ready=1 -> rx_valid=0 next cycle.
- Wait states: pready low 3 cycles on the LSR read -> penable held 4 cycles and paddr=0x014 stable throughout; the decision uses prdata sampled with pready.
- Error: pslverr=1 on the DLM write -> err=1, init_done=0, no further pselx. cfg_start -> err=0 and full init re-runs.
- Async reset asserted during ACCESS of a THR write -> pselx/penable=0 the same cycle; after release, no bus activity until cfg_start.

Source files
------------

// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART sequencer: 16550 register map,
// LSR bit positions and the state encodings of both FSMs.
package apb_uart_pkg;

  // Register indices; byte address is BASE_ADDR + (index << 2).
  localparam logic [2:0] REG_RBR = 3'd0;
  localparam logic [2:0] REG_THR = 3'd0;
  localparam logic [2:0] REG_DLL = 3'd0;
  localparam logic [2:0] REG_IER = 3'd1;
  localparam logic [2:0] REG_DLM = 3'd1;
  localparam logic [2:0] REG_IIR = 3'd2;
  localparam logic [2:0] REG_FCR = 3'd2;
  localparam logic [2:0] REG_LCR = 3'd3;
  localparam logic [2:0] REG_MCR = 3'd4;
  localparam logic [2:0] REG_LSR = 3'd5;
  localparam logic [2:0] REG_MSR = 3'd6;
  localparam logic [2:0] REG_SCR = 3'd7;

  // Line status bits used by the poll loop.
  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;

  // Index of the last write in the init sequence (six writes, 0..5).
  localparam logic [2:0] INIT_LAST = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_POLL_LSR,
    ST_RD_RBR,
    ST_WR_THR,
    ST_HALT
  } main_state_e;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  // One step of the init sequence: which register and what byte.
  typedef struct packed {
    logic [2:0] reg_idx;
    logic [7:0] data;
  } init_op_t;

endpackage

// File: rtl/apb_uart_master_if.sv
// APB3 SETUP/ACCESS engine. A one-cycle req pulse while idle launches a
// transfer; address, direction and write data are latched at that point
// and held on the bus until the slave answers with pready. done, rdata and
// slverr are valid only in the completing ACCESS cycle.
//
// Handshake: req is a single-cycle pulse that is only issued while the
// engine is idle; done is high for exactly the cycle in which pready=1
// closes the ACCESS phase, and the engine is idle again the next cycle.
module apb_uart_master_if
  import apb_uart_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  slverr,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pselx,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  // Next-state and launch-time capture of the transfer attributes.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      APB_IDLE: begin
        if (req) begin
          state_d = APB_SETUP;
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
        end
      end
      APB_SETUP:  state_d = APB_ACCESS;
      APB_ACCESS: if (pready) state_d = APB_IDLE;
      default:    state_d = APB_IDLE;
    endcase
  end

  // State and bus attribute registers; reset drops the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= APB_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign pselx   = (state_q != APB_IDLE);
  assign penable = (state_q == APB_ACCESS);
  assign paddr   = addr_q;
  assign pwrite  = we_q;
  assign pwdata  = wdata_q;

  assign done    = (state_q == APB_ACCESS) && pready;
  assign rdata   = prdata;
  assign slverr  = done && pslverr;

endmodule

// File: rtl/apb_uart_ctrl.sv
// Sequencer for a 16550-style APB UART: runs the six-write init sequence,
// then polls LSR forever, reading RBR into a one-byte holding register and
// writing bytes from the tx stream into THR.
//
// Stream handshakes: a byte moves when valid && ready are both high at a
// clock edge. tx_ready is only raised in the cycle after an LSR read
// completes (the decision cycle) and tx_data is sampled only then.
// rx_valid holds until the consumer raises rx_ready.
module apb_uart_ctrl
  import apb_uart_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 12'h000,
  parameter logic [15:0]           DIVISOR    = 16'd27,
  parameter logic [7:0]            LCR_VAL    = 8'h03,
  parameter logic [7:0]            FCR_VAL    = 8'h07,
  parameter logic [7:0]            IER_VAL    = 8'h00
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cfg_start,
  output logic                  init_done,
  output logic                  err,
  input  logic                  tx_valid,
  input  logic [7:0]            tx_data,
  output logic                  tx_ready,
  output logic                  rx_valid,
  output logic [7:0]            rx_data,
  input  logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pselx,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  // Init sequence table: DLAB on, divisor low/high, DLAB off, FIFO, IER.
  function automatic init_op_t init_op(input logic [2:0] step);
    init_op_t op;
    case (step)
      3'd0:    op = '{reg_idx: REG_LCR, data: LCR_VAL | 8'h80};
      3'd1:    op = '{reg_idx: REG_DLL, data: DIVISOR[7:0]};
      3'd2:    op = '{reg_idx: REG_DLM, data: DIVISOR[15:8]};
      3'd3:    op = '{reg_idx: REG_LCR, data: LCR_VAL & 8'h7F};
      3'd4:    op = '{reg_idx: REG_FCR, data: FCR_VAL};
      default: op = '{reg_idx: REG_IER, data: IER_VAL};
    endcase
    return op;
  endfunction

  main_state_e state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [2:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        decide_q, decide_d;
  logic [7:0]  lsr_q, lsr_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        err_q, err_d;
  logic        init_done_q, init_done_d;
  init_op_t    op;

  logic                  xfer_done;
  logic [DATA_WIDTH-1:0] xfer_rdata;
  logic                  xfer_slverr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [7:0]            rdata_unused;

  assign req_addr     = BASE_ADDR + ADDR_WIDTH'({reg_q, 2'b00});
  assign rdata_unused = xfer_rdata[7:0];

  // Main sequencing: init writes, LSR poll, RBR read / THR write decision.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    req_d       = 1'b0;
    we_d        = we_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    decide_d    = 1'b0;
    lsr_d       = lsr_q;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    err_d       = err_q;
    init_done_d = init_done_q;
    tx_ready    = 1'b0;
    op          = init_op(3'd0);

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (cfg_start) begin
          err_d       = 1'b0;
          init_done_d = 1'b0;
          step_d      = 3'd0;
          state_d     = ST_INIT;
          op          = init_op(3'd0);
          req_d       = 1'b1;
          we_d        = 1'b1;
          reg_d       = op.reg_idx;
          wdata_d     = op.data;
        end
      end
      ST_INIT: begin
        if (xfer_done) begin
          if (xfer_slverr) begin
            err_d       = 1'b1;
            init_done_d = 1'b0;
            state_d     = ST_HALT;
          end else if (step_q == INIT_LAST) begin
            init_done_d = 1'b1;
            state_d     = ST_POLL_LSR;
            req_d       = 1'b1;
            we_d        = 1'b0;
            reg_d       = REG_LSR;
            wdata_d     = 8'h00;
          end else begin
            step_d  = step_q + 3'd1;
            op      = init_op(step_q + 3'd1);
            req_d   = 1'b1;
            we_d    = 1'b1;
            reg_d   = op.reg_idx;
            wdata_d = op.data;
          end
        end
      end
      ST_POLL_LSR: begin
        if (xfer_done) begin
          if (xfer_slverr) begin
            err_d       = 1'b1;
            init_done_d = 1'b0;
            state_d     = ST_HALT;
          end else begin
            lsr_d    = xfer_rdata[7:0];
            decide_d = 1'b1;
          end
        end else if (decide_q) begin
          // RX wins over TX; a held rx byte blocks further RBR reads.
          if (lsr_q[LSR_DR] && !rx_valid_q) begin
            state_d = ST_RD_RBR;
            req_d   = 1'b1;
            we_d    = 1'b0;
            reg_d   = REG_RBR;
            wdata_d = 8'h00;
          end else if (lsr_q[LSR_THRE] && tx_valid) begin
            tx_ready = 1'b1;
            state_d  = ST_WR_THR;
            req_d    = 1'b1;
            we_d     = 1'b1;
            reg_d    = REG_THR;
            wdata_d  = tx_data;
          end else begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            reg_d   = REG_LSR;
            wdata_d = 8'h00;
          end
        end
      end
      ST_RD_RBR, ST_WR_THR: begin
        if (xfer_done) begin
          if (xfer_slverr) begin
            err_d       = 1'b1;
            init_done_d = 1'b0;
            state_d     = ST_HALT;
          end else begin
            if (state_q == ST_RD_RBR) begin
              rx_data_d  = xfer_rdata[7:0];
              rx_valid_d = 1'b1;
            end
            state_d = ST_POLL_LSR;
            req_d   = 1'b1;
            we_d    = 1'b0;
            reg_d   = REG_LSR;
            wdata_d = 8'h00;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Main FSM and its registered outputs.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      step_q      <= 3'd0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      reg_q       <= 3'd0;
      wdata_q     <= 8'h00;
      decide_q    <= 1'b0;
      lsr_q       <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      req_q       <= req_d;
      we_q        <= we_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      decide_q    <= decide_d;
      lsr_q       <= lsr_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_done = init_done_q;
  assign err       = err_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;

  apb_uart_master_if #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_master (
    .clk     (pclk),
    .rst     (preset),
    .req     (req_q),
    .we      (we_q),
    .addr    (req_addr),
    .wdata   ({{(DATA_WIDTH-8){1'b0}}, wdata_q}),
    .done    (xfer_done),
    .rdata   (xfer_rdata),
    .slverr  (xfer_slverr),
    .paddr   (paddr),
    .pselx   (pselx),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

endmodule

// File: tb/tb_apb_uart_ctrl.sv
// Bench for apb_uart_ctrl: APB slave model with knobs for LSR/RBR values,
// wait states and error injection; every non-LSR transfer is checked
// against an expected queue by an independent bus monitor.
module tb_apb_uart_ctrl;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int W  = 1 + AW + DW;
  localparam logic [AW-1:0] A_RBR = 12'h000;
  localparam logic [AW-1:0] A_LSR = 12'h014;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  // ---------------- DUT connections ----------------
  logic          cfg_start = 1'b0;
  logic          init_done, err;
  logic          tx_valid = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          tx_ready;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready = 1'b0;
  logic [AW-1:0] paddr;
  logic          pselx, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  apb_uart_ctrl dut (
    .pclk      (pclk),
    .preset    (preset),
    .cfg_start (cfg_start),
    .init_done (init_done),
    .err       (err),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .paddr     (paddr),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
    exp_q.push_back({1'b1, a, 24'h0, d});
  endtask

  task automatic push_rd(input logic [AW-1:0] a);
    exp_q.push_back({1'b0, a, 32'h0});
  endtask

  task automatic push_init();
    push_wr(12'h00C, 8'h83);
    push_wr(12'h000, 8'h1B);
    push_wr(12'h004, 8'h00);
    push_wr(12'h00C, 8'h03);
    push_wr(12'h008, 8'h07);
    push_wr(12'h004, 8'h00);
  endtask

  // ---------------- APB slave model ----------------
  logic [7:0]    lsr_val = 8'h00;
  logic [7:0]    rbr_val = 8'h00;
  int            wait_lsr = 0;
  int            wait_thr = 0;
  int            wcnt = 0;
  int            need = 0;
  logic          err_arm = 1'b0;
  logic [AW-1:0] err_addr = 12'h004;

  always @(posedge pclk) begin
    #1;
    if (pselx && penable) begin
      need = (!pwrite && paddr == A_LSR) ? wait_lsr :
             ( pwrite && paddr == A_RBR) ? wait_thr : 0;
      if (wcnt < need) begin
        wcnt++;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0000_00FF;   // decoy: must not be used before pready
      end else begin
        wcnt    = 0;
        pready  = 1'b1;
        prdata  = pwrite ? 32'h0 :
                  (paddr == A_LSR) ? {24'h0, lsr_val} :
                  (paddr == A_RBR) ? {24'h0, rbr_val} : 32'h0;
        pslverr = err_arm && pwrite && (paddr == err_addr);
        if (pslverr) err_arm = 1'b0;
      end
    end else begin
      wcnt    = 0;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
    end
  end

  // ---------------- bus monitor ----------------
  int            cyc = 0;
  int            sel_cycles = 0;
  int            lsr_reads = 0;
  int            tx_pulses = 0;
  int            acc_len = 0;
  int            last_lsr_len = 0;
  int            cmp_cyc[$];
  logic          stable = 1'b1;
  logic [AW-1:0] s_addr;
  logic          s_we;
  logic [DW-1:0] s_wd;
  logic [W-1:0]  act_w, exp_w;

  always @(negedge pclk) begin
    cyc++;
    if (tx_ready) tx_pulses++;
    if (pselx) sel_cycles++;
    if (pselx && !penable) begin
      s_addr  = paddr;
      s_we    = pwrite;
      s_wd    = pwdata;
      acc_len = 0;
      stable  = 1'b1;
    end
    if (pselx && penable) begin
      acc_len++;
      if (paddr !== s_addr || pwrite !== s_we || pwdata !== s_wd) stable = 1'b0;
      if (pready) begin
        cmp_cyc.push_back(cyc);
        check("xfer_stable", stable, 1'b1);
        if (!pwrite && paddr == A_LSR) begin
          lsr_reads++;
          last_lsr_len = acc_len;
        end else if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_xfer: got we=%0b addr=0x%0h data=0x%0h, expected no transfer",
                   pwrite, paddr, pwdata);
        end else begin
          exp_w = exp_q.pop_front();
          act_w = {pwrite, paddr, pwrite ? pwdata : 32'h0};
          check("apb_xfer", act_w, exp_w);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  int tgt = 0;

  function automatic bit cond(input int which);
    case (which)
      0:       return init_done;
      1:       return err;
      2:       return rx_valid;
      3:       return tx_ready;
      4:       return exp_q.size() == 0;
      5:       return lsr_reads >= tgt;
      6:       return pselx && penable && pwrite && (paddr == A_RBR);
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int max, input string name);
    for (int i = 0; i < max; i++) begin
      @(negedge pclk);
      if (cond(which)) break;
    end
    check(name, cond(which), 1'b1);
  endtask

  task automatic pulse_cfg();
    @(negedge pclk);
    cfg_start = 1'b1;
    @(negedge pclk);
    cfg_start = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  int tp0, s0;

  initial begin
    repeat (3) @(negedge pclk);
    check("rst_pselx", pselx, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_paddr", paddr, 12'h000);
    check("rst_pwdata", pwdata, 32'h0);
    preset = 1'b0;
    repeat (5) @(negedge pclk);
    check("idle_no_bus", sel_cycles, 0);

    // Init sequence with zero wait states.
    push_init();
    cmp_cyc.delete();
    pulse_cfg();
    wait_for(0, 200, "init_done_rise");
    check("init_err", err, 1'b0);
    check("init_q_empty", exp_q.size(), 0);
    check("init_xfer_count", cmp_cyc.size() >= 6, 1'b1);
    if (cmp_cyc.size() >= 6) check("init_span_cycles", cmp_cyc[5] - cmp_cyc[0], 15);

    // cfg_start while polling is ignored (no init writes are expected).
    pulse_cfg();
    repeat (30) @(negedge pclk);
    check("busy_cfg_ignored", init_done, 1'b1);

    // LSR=0x00: tx_valid must never be accepted.
    tp0 = tx_pulses;
    tx_data = 8'h11;
    tx_valid = 1'b1;
    tgt = lsr_reads + 20;
    wait_for(5, 400, "tx_idle_20_polls");
    check("tx_idle_no_ready", tx_pulses - tp0, 0);
    tx_valid = 1'b0;

    // LSR=0x60: one tx_ready pulse, then THR write of 0xA5.
    tp0 = tx_pulses;
    push_wr(A_RBR, 8'hA5);
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    lsr_val = 8'h60;
    wait_for(3, 100, "tx_ready_seen");
    @(posedge pclk);
    #1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    lsr_val = 8'h00;
    wait_for(4, 50, "tx_thr_written");
    check("tx_single_pulse", tx_pulses - tp0, 1);

    // RX with backpressure: LSR=0x61, RBR=0x3C, consumer stalled.
    rbr_val = 8'h3C;
    push_rd(A_RBR);
    lsr_val = 8'h61;
    wait_for(2, 100, "rx_valid_rise");
    check("rx_data", rx_data, 8'h3C);
    push_wr(A_RBR, 8'h5A);
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    wait_for(3, 100, "tx_while_rx_held");
    @(posedge pclk);
    #1;
    tx_valid = 1'b0;
    tgt = lsr_reads + 20;
    wait_for(5, 400, "rx_held_20_polls");
    check("rx_held_q_empty", exp_q.size(), 0);
    check("rx_still_valid", rx_valid, 1'b1);
    check("rx_data_held", rx_data, 8'h3C);
    lsr_val = 8'h00;
    repeat (10) @(negedge pclk);
    rx_ready = 1'b1;
    @(negedge pclk);
    rx_ready = 1'b0;
    check("rx_cleared", rx_valid, 1'b0);

    // Wait states on LSR: decoy data during waits, real LSR=0x00 at pready.
    tp0 = tx_pulses;
    tx_data = 8'h77;
    tx_valid = 1'b1;
    wait_lsr = 3;
    tgt = lsr_reads + 5;
    wait_for(5, 300, "ws_5_polls");
    check("ws_penable_cycles", last_lsr_len, 4);
    check("ws_no_tx", tx_pulses - tp0, 0);
    check("ws_no_rx", rx_valid, 1'b0);
    wait_lsr = 0;
    tx_valid = 1'b0;
    repeat (10) @(negedge pclk);

    // Error on DLM write halts; cfg_start clears err and re-runs init.
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge pclk);
    err_addr = 12'h004;
    err_arm = 1'b1;
    push_wr(12'h00C, 8'h83);
    push_wr(12'h000, 8'h1B);
    push_wr(12'h004, 8'h00);
    pulse_cfg();
    wait_for(1, 100, "err_rise");
    check("err_init_done_low", init_done, 1'b0);
    s0 = sel_cycles;
    repeat (20) @(negedge pclk);
    check("halt_no_bus", sel_cycles - s0, 0);
    check("halt_q_empty", exp_q.size(), 0);
    push_init();
    pulse_cfg();
    check("err_cleared", err, 1'b0);
    wait_for(0, 200, "reinit_done");
    check("reinit_err", err, 1'b0);
    check("reinit_q_empty", exp_q.size(), 0);

    // Async reset during ACCESS of a THR write.
    wait_thr = 5;
    tx_data = 8'hC3;
    tx_valid = 1'b1;
    lsr_val = 8'h60;
    wait_for(6, 100, "thr_access_seen");
    preset = 1'b1;
    #1;
    check("rst_mid_pselx", pselx, 1'b0);
    check("rst_mid_penable", penable, 1'b0);
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    s0 = sel_cycles;
    tp0 = tx_pulses;
    repeat (20) @(negedge pclk);
    check("post_rst_no_bus", sel_cycles - s0, 0);
    check("post_rst_no_tx", tx_pulses - tp0, 0);
    check("post_rst_init_done", init_done, 1'b0);
    check("post_rst_rx_valid", rx_valid, 1'b0);
    tx_valid = 1'b0;
    check("final_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule
